cga_vram_arbiter: RTL

- Shares the single video RAM port between the display fetch path and the ISA host (CPU reads/writes of the CGA/Tandy frame buffer).
- Display fetches always win. Host operations are queued one-deep and run as fixed 3-cycle operations, only inside the windows flagged by the sequencer's isa_op_enable.
- Drives the host wait line (IOCHRDY-style) and returns read data.
- Sits between the sequencer, the CRTC/address generator, the ISA bus interface and the VRAM.

---
 rtl/cga_pkg.sv | 15 +
 rtl/cga_vram_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA/Tandy video RAM arbiter.
package cga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_OP2  = 2'd2,
    ST_OP3  = 2'd3
  } arb_state_t;

  localparam int OP_CYCLES    = 3;
  localparam int CGA_ADDR_W   = 14;
  localparam int TANDY_ADDR_W = 15;

endpackage

// File: rtl/cga_vram_arbiter.sv
// Shares the VRAM port between display fetch and a one-deep queued ISA host op.
// Display fetch always owns the address; host ops run as fixed 3-cycle slots.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int ADDR_W = CGA_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isa_op_enable,
  input  logic              vram_read,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              collision
);

  arb_state_t        state, next_state;
  logic              op_active;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;

  always_comb begin
    next_state = state;
    op_active  = 1'b0;
    case (state)
      ST_IDLE: if (cpu_req) next_state = ST_PEND;
      ST_PEND: begin
        if (isa_op_enable) begin
          next_state = ST_OP2;
          op_active  = 1'b1;
        end
      end
      ST_OP2: begin
        next_state = ST_OP3;
        op_active  = 1'b1;
      end
      ST_OP3: begin
        next_state = ST_IDLE;
        op_active  = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Video always wins the address; a clashing host write is suppressed.
  always_comb begin
    ram_addr = (op_active && !vram_read) ? lat_addr : video_addr;
    ram_din  = lat_din;
    ram_we   = (state == ST_OP2) && lat_we && !vram_read && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_dout  <= '0;
      cpu_ack   <= 1'b0;
      cpu_wait  <= 1'b0;
      collision <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_din   <= '0;
    end else begin
      state    <= next_state;
      cpu_ack  <= (state == ST_OP3);
      cpu_wait <= (next_state != ST_IDLE);
      if (state == ST_IDLE && cpu_req) begin
        lat_we   <= cpu_we;
        lat_addr <= cpu_addr;
        lat_din  <= cpu_din;
      end
      // RAM data for the address presented in OP2 arrives during OP3.
      if (state == ST_OP3 && !lat_we) cpu_dout <= ram_dout;
      if (op_active && vram_read) collision <= 1'b1;
    end
  end

endmodule
